// File: rtl/mult16s_accum_pkg.sv
// rtl/mult16s_accum_pkg.sv - shared constants, state enum and sign-extension helper for the product accumulator
package mult16s_accum_pkg;

    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;
    localparam int CNT_W_DEF  = 8;

    // Widest product/accumulator the sign-extension helper supports.
    localparam int SEXT_MAX_W = 64;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Sign-extend the low w bits of v to SEXT_MAX_W bits.
    // The value is shifted up to the top, then shifted back down arithmetically.
    function automatic logic [SEXT_MAX_W-1:0] sext64(input logic [SEXT_MAX_W-1:0] v,
                                                     input int unsigned w);
        logic signed [SEXT_MAX_W-1:0] t;
        t = $signed(v << (SEXT_MAX_W - w));
        return t >>> (SEXT_MAX_W - w);
    endfunction

endpackage

// File: rtl/mult16s_acc_adder.sv
// rtl/mult16s_acc_adder.sv - combinational signed add with overflow detect; clamps under MULT16S_ACCUM_SATURATE_EN
module mult16s_acc_adder #(
    parameter int ACC_W = 40
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [ACC_W-1:0] raw_sum;

    // Two's complement add; overflow when the addends share a sign and the sum does not.
    always_comb begin
        raw_sum = a_i + b_i;
        ovf_o   = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw_sum[ACC_W-1] != a_i[ACC_W-1]);
`ifdef MULT16S_ACCUM_SATURATE_EN
        if (ovf_o) begin
            sum_o = a_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum_o = raw_sum;
        end
`else
        sum_o = raw_sum;
`endif
    end

endmodule

// File: rtl/mult16s_product_accumulator.sv
// rtl/mult16s_product_accumulator.sv - signed product dot-product accumulator; optional clamp via MULT16S_ACCUM_SATURATE_EN
module mult16s_product_accumulator
    import mult16s_accum_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    assign prod_ext = ACC_W'(sext64(SEXT_MAX_W'(in_product), PROD_W));
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    assign out_valid    = (state_q == HOLD);
    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign out_acc      = out_acc_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_ovf_q;

    // acc_q is already cleared while in HOLD, so a product accepted there starts a fresh sequence.
    mult16s_acc_adder #(.ACC_W(ACC_W)) u_adder (
        .a_i   (acc_q),
        .b_i   (prod_ext),
        .sum_o (sum),
        .ovf_o (add_ovf)
    );

    // Next-state: accumulate, close a sequence into the result registers, or release a held result.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (state_q == HOLD && out_ready) begin
            state_d = ACCUM;
        end

        if (accept) begin
            if (in_last) begin
                out_acc_d   = sum;
                out_count_d = cnt_inc;
                out_ovf_d   = ovf_q | add_ovf;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                state_d     = HOLD;
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
                ovf_d = ovf_q | add_ovf;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_mult16s_product_accumulator.sv
// tb/tb_mult16s_product_accumulator.sv - scoreboard bench for the product accumulator (default and narrow instances)
module tb_mult16s_product_accumulator;

    typedef struct packed {
        logic [39:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_product = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        a_in_ready, a_out_valid, a_out_overflow;
    logic [39:0] a_out_acc;
    logic [7:0]  a_out_count;
    logic        b_in_ready, b_out_valid, b_out_overflow;
    logic [33:0] b_out_acc;
    logic [1:0]  b_out_count;

    exp_t qa[$];
    exp_t qb[$];
    int   a_pops[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mult16s_product_accumulator u_a (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (a_in_ready),
        .in_product   (in_product),
        .in_last      (in_last),
        .out_valid    (a_out_valid),
        .out_ready    (out_ready),
        .out_acc      (a_out_acc),
        .out_count    (a_out_count),
        .out_overflow (a_out_overflow)
    );

    mult16s_product_accumulator #(.ACC_W(34), .CNT_W(2)) u_b (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (b_in_ready),
        .in_product   (in_product),
        .in_last      (in_last),
        .out_valid    (b_out_valid),
        .out_ready    (out_ready),
        .out_acc      (b_out_acc),
        .out_count    (b_out_count),
        .out_overflow (b_out_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (a_out_valid && out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result", 64'(a_out_acc), 64'hDEAD);
            end else begin
                exp_t e;
                e = qa.pop_front();
                a_pops.push_back(cyc);
                chk("a_out_acc", 64'(a_out_acc), 64'(e.acc));
                chk("a_out_count", 64'(a_out_count), 64'(e.cnt));
                chk("a_out_overflow", 64'(a_out_overflow), 64'(e.ovf));
            end
        end
    end

    // Monitor for the narrow (ACC_W=34, CNT_W=2) instance.
    always @(negedge clk) begin
        if (b_out_valid && out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result", 64'(b_out_acc), 64'hDEAD);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_out_acc", 64'(b_out_acc), 64'(e.acc[33:0]));
                chk("b_out_count", 64'(b_out_count), 64'(e.cnt[1:0]));
                chk("b_out_overflow", 64'(b_out_overflow), 64'(e.ovf));
            end
        end
    end

    task automatic send(input logic [31:0] p, input logic l);
        int w;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = l;
        w = 0;
        @(negedge clk);
        while (!a_in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!a_in_ready) chk("send_timeout", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push(input logic [39:0] aa, input logic [7:0] ac, input logic ao,
                        input logic [39:0] ba, input logic [7:0] bc, input logic bo);
        qa.push_back('{acc: aa, cnt: ac, ovf: ao});
        qb.push_back('{acc: ba, cnt: bc, ovf: bo});
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((qa.size() != 0 || qb.size() != 0) && w < 40) begin
            w++;
            @(negedge clk);
        end
        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        int w;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_acc", 64'(a_out_acc), 64'd0);
        chk("rst_out_count", 64'(a_out_count), 64'd0);
        chk("rst_out_overflow", 64'(a_out_overflow), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Mid-sequence reset discards the partial sum
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        send(32'd30, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
        @(posedge clk);
        #1;
        push(40'd5, 8'd1, 1'b0, 40'd5, 8'd1, 1'b0);
        send(32'd5, 1'b1);
        drain();

        // Basic three-product sequence
        push(40'h003FFF0001, 8'd3, 1'b0, 40'h03FFF0001, 8'd3, 1'b0);
        send(32'h00000064, 1'b0);
        send(32'hFFFFFF9C, 1'b0);
        send(32'h3FFF0001, 1'b1);
        drain();

        // Back-to-back single-product sequences, no bubble between results
        n0 = a_pops.size();
        push(40'd7, 8'd1, 1'b0, 40'd7, 8'd1, 1'b0);
        push(40'hFFFFFFFFF9, 8'd1, 1'b0, 40'h3FFFFFFF9, 8'd1, 1'b0);
        send(32'h00000007, 1'b1);
        send(32'hFFFFFFF9, 1'b1);
        drain();
        if (a_pops.size() >= n0 + 2) chk("b2b_gap", 64'(a_pops[n0+1] - a_pops[n0]), 64'd1);
        else chk("b2b_pop_count", 64'(a_pops.size() - n0), 64'd2);

        // Backpressure: result held, input blocked, then next sequence starts from zero
        out_ready = 1'b0;
        push(40'h11, 8'd1, 1'b0, 40'h11, 8'd1, 1'b0);
        send(32'h00000011, 1'b1);
        in_valid   = 1'b1;
        in_product = 32'h00000099;
        in_last    = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_a_in_ready", 64'(a_in_ready), 64'd0);
            chk("bp_b_in_ready", 64'(b_in_ready), 64'd0);
            chk("bp_a_out_valid", 64'(a_out_valid), 64'd1);
            chk("bp_a_out_acc", 64'(a_out_acc), 64'h11);
            chk("bp_a_out_count", 64'(a_out_count), 64'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        push(40'h9A, 8'd2, 1'b0, 40'h9A, 8'd2, 1'b0);
        send(32'h00000001, 1'b1);
        drain();

        // Overflow: 8 x 2^30 overflows 34 bits but not 40 bits
`ifdef MULT16S_ACCUM_SATURATE_EN
        push(40'h0200000000, 8'd8, 1'b0, 40'h01FFFFFFFF, 8'd3, 1'b1);
`else
        push(40'h0200000000, 8'd8, 1'b0, 40'h0200000000, 8'd3, 1'b1);
`endif
        for (int i = 0; i < 8; i++) send(32'h40000000, (i == 7));
        drain();

        // Count saturation on the 2-bit counter
        push(40'd5, 8'd5, 1'b0, 40'd5, 8'd3, 1'b0);
        for (int i = 0; i < 5; i++) send(32'd1, (i == 4));
        drain();

        w = 0;
        while (w < 3) begin
            w++;
            @(negedge clk);
        end
        chk("final_idle", 64'(a_out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult16s_product_accumulator.md
Name: mult16s_product_accumulator

Overview:
- Downstream consumer of the registered 32-bit signed product from the 16x16 signed Booth-4/Sklansky multiplier wrapper.
- Sign-extends each accepted product and sums it into an ACC_W-bit signed accumulator, building one dot-product result per sequence.
- The input flag in_last closes a sequence. The result then appears on a valid/ready output together with the product count and an overflow flag.

Parameters:
- PROD_W, 32, product width; signed two's complement.
- ACC_W, 40, accumulator and result width; must be >= PROD_W.
- CNT_W, 8, width of the products-per-result counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_product and in_last are valid.
- in_ready  output  1  block accepts the input this cycle.
- in_product  input  PROD_W  signed product from the multiplier stage.
- in_last  input  1  this product closes the current sequence.
- out_valid  output  1  result held on the out_* ports.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  signed accumulated sum.
- out_count  output  CNT_W  number of products in this result; saturates at 2^CNT_W-1.
- out_overflow  output  1  sticky: signed overflow occurred during this sequence.

Behaviour:
- Reset, and state on return from reset:
  - out_valid=0, out_acc=0, out_count=0, out_overflow=0.
  - Internal acc=0, cnt=0, ovf=0, state=ACCUM.
  - rst asserted mid-sequence discards the partial sum and any pending result. No output is produced for that sequence.
- Input handshake: in_ready = !out_valid || out_ready. A transfer occurs when in_valid && in_ready.
- Output handshake: transfer when out_valid && out_ready. out_* are stable while out_valid && !out_ready.
- States:
  - ACCUM: out_valid=0.
  - HOLD: out_valid=1.
- Accept, non-last product:
  - acc <= acc + sext(in_product).
  - cnt <= cnt+1, saturating.
  - ovf <= ovf | add_ovf.
- Accept with in_last=1:
  - out_acc <= acc + sext(in_product); out_count <= cnt+1, saturating; out_overflow <= ovf | add_ovf.
  - acc, cnt, ovf cleared to 0; state goes to HOLD.
  - Latency: result is visible on the cycle after the last product is accepted.
- A single-product sequence (first product has in_last=1) is legal. It yields out_count=1 and out_acc=sext(product).
- HOLD with out_ready=1 and no new last-product: go to ACCUM, out_valid drops next cycle.
- HOLD with out_ready=1 and an accepted product in the same cycle:
  - The product starts the next sequence from the cleared accumulator.
  - If that product has in_last=1, stay in HOLD and load the new result. This gives back-to-back results with no bubble.
- HOLD with out_ready=0: in_ready=0 and the accumulator is frozen.
- Overflow rules:
  - add_ovf is set when both addends share a sign and the sum's sign differs.
  - Without the optional feature, the sum wraps modulo 2^ACC_W.
- in_valid=0 never changes acc, cnt or ovf.

Optional Feature:
- MULT16S_ACCUM_SATURATE_EN.
- Defined: on add_ovf the sum clamps to 2^(ACC_W-1)-1 for positive overflow or -2^(ACC_W-1) for negative overflow. The overflow flag is still set.
- Undefined: wrap-around arithmetic; the overflow flag is the only indication.

Decomposition:
- Package mult16s_accum_pkg holds:
  - default PROD_W, ACC_W and CNT_W constants;
  - the state enum {ACCUM, HOLD};
  - a sign-extension function.
- Sub-module mult16s_acc_adder: combinational signed ACC_W add producing sum and ovf, with the saturation clamp under the macro. Registers and the FSM stay in the top module.

Test Plan:
- Reset behaviour: assert rst for 2 cycles mid-sequence after 3 products, then feed 0x00000005 with last -> out_acc=5, out_count=1, out_overflow=0; the partial sum is not visible.
- Basic sequence with out_ready=1: feed 0x00000064, 0xFFFFFF9C, 0x3FFF0001 with last -> one cycle later out_valid=1, out_acc=0x003FFF0001, out_count=3, out_overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and out_* stable; release out_ready -> next sequence starts from 0.
- Back-to-back: two single-product sequences (0x00000007 last, then 0xFFFFFFF9 last) with out_ready=1 -> consecutive results 7 and -7 (0xFFFFFFFFF9), no idle cycle between them.
- Overflow with ACC_W=34: 8 products of 0x40000000, last on the 8th:
  - without the macro -> out_acc=0x200000000 (wrapped), out_overflow=1;
  - with MULT16S_ACCUM_SATURATE_EN -> out_acc=0x1FFFFFFFF, out_overflow=1.
- Count saturation with CNT_W=2: 5 products of 1, last on the 5th -> out_count=3, out_acc=5.
